// File: rtl/mips_pkg.sv
// Shared definitions for the execute-stage multi-cycle units: FSM state
// encoding and counter sizing for the shift-add multiplier.
package mips_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PREP = 3'd1,
      ST_CALC = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // Enough bits to hold the iteration count WIDTH itself, not just WIDTH-1.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/adder.sv
// Plain ripple-style adder with carry-in, shared by the execute datapath.
// The carry-in lets callers form ~x + 1 without a separate constant operand.
module Adder #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum
);

   assign sum = a + b + {{(WIDTH-1){1'b0}}, cin};

endmodule

// File: rtl/mult_sequencer.sv
// Shift-add sequencer for MULT/MULTU: one partial product per clock through a
// shared adder, then an optional two's-complement fix-up into hi/lo.
module mult_sequencer
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = cnt_width(WIDTH);

   state_t              state;
   state_t              state_nxt;
   logic [CW-1:0]       count;
   logic [WIDTH-1:0]    mcand;
   logic [WIDTH-1:0]    acc;
   logic [WIDTH-1:0]    lo_reg;
   logic                sgn;
   logic                neg;
   logic [WIDTH:0]      iter_addend;
   logic [WIDTH:0]      iter_sum;
   logic [2*WIDTH-1:0]  neg_sum;

   // The most negative value maps onto itself, which is correct when read as
   // an unsigned magnitude.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic s);
      return (s && v[WIDTH-1]) ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
   endfunction

   assign iter_addend = lo_reg[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}};

   Adder #(.WIDTH(WIDTH + 1)) u_iter_add (
      .a   ({1'b0, acc}),
      .b   (iter_addend),
      .cin (1'b0),
      .sum (iter_sum)
   );

   Adder #(.WIDTH(2 * WIDTH)) u_neg_add (
      .a   (~{acc, lo_reg}),
      .b   ({(2*WIDTH){1'b0}}),
      .cin (1'b1),
      .sum (neg_sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Datapath registers; hi/lo are only written in FIX so a previous result
   // stays readable while the next operation is in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= '0;
         mcand  <= '0;
         acc    <= '0;
         lo_reg <= '0;
         sgn    <= 1'b0;
         neg    <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  mcand  <= op_a;
                  lo_reg <= op_b;
                  sgn    <= is_signed;
                  neg    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
               end
            end
            ST_PREP: begin
               mcand  <= magnitude(mcand, sgn);
               lo_reg <= magnitude(lo_reg, sgn);
               acc    <= '0;
               count  <= CW'(WIDTH);
            end
            ST_CALC: begin
               acc    <= iter_sum[WIDTH:1];
               lo_reg <= {iter_sum[0], lo_reg[WIDTH-1:1]};
               count  <= count - CW'(1);
            end
            ST_FIX: begin
               if (neg) begin
                  {hi, lo} <= neg_sum;
               end else begin
                  {hi, lo} <= {acc, lo_reg};
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_PREP;
            end
         end
         ST_PREP: begin
            busy      = 1'b1;
            state_nxt = ST_CALC;
         end
         ST_CALC: begin
            busy = 1'b1;
            if (count == CW'(1)) begin
               state_nxt = ST_FIX;
            end
         end
         ST_FIX: begin
            busy      = 1'b1;
            state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule
